lc3_ctrl_fsm: RTL and testbench
===============================

Name: lc3_ctrl_fsm

Overview:
Multi-cycle control sequencer for the LC-3 datapath. Steps fetch, decode and execute, and drives every load-enable, bus-gate and mux-select, including flagWE to the NZP flag register. Consumes IR and the N/Z/P flags to resolve BR. Handshakes with a variable-latency memory.

Parameters:
RESET_PC, 16'h3000, value requested on pc_init during reset (datapath loads PC from it)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
IR  in  16  current instruction register
N, Z, P  in  1 each  condition flags
mem_rdy  in  1  memory completed the current access this cycle
ldPC, ldIR, ldMAR, ldMDR, ldReg, flagWE  out  1 each  register load enables
gatePC, gateMDR, gateALU, gateMARMUX  out  1 each  Buss drivers; at most one high per cycle
selPC  out  2  00 PC+1, 01 EAB, 10 Buss
selEAB1  out  1  0 PC, 1 SR1
selEAB2  out  2  00 zero, 01 off6, 10 off9, 11 off11
selMAR  out  1  0 EAB, 1 zext(IR[7:0])
selMDR  out  1  0 Buss, 1 memory data
aluControl  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS
DR, SR1, SR2  out  3 each  register selects (DR=7 for JSR/TRAP)
mem_en, memWE  out  1 each  memory request; write qualifier
pc_init  out  16  RESET_PC

Behaviour:
- rst=1 at a clock edge: state goes to FETCH0; all enables, gates, mem_en and memWE are 0; selects are 0; ldPC=1 with selPC=10 and gatePC=0, so the datapath loads pc_init. Reset mid-access abandons the access. Any mem_rdy during reset is ignored.
- States: FETCH0, FETCH1, FETCH2, DECODE, EX_ALU, EX_BR, EX_JMP, EX_JSR0, EX_JSR1, EX_EA, EX_IND0, EX_IND1, EX_RD0, EX_RD1, EX_WR0, EX_WR1, EX_LEA, EX_TRAP0, EX_TRAP1, HALT (HALT only under option).
- FETCH0: gatePC, ldMAR, ldPC (PC+1). FETCH1: mem_en, selMDR=1, ldMDR gated by mem_rdy. Stay in FETCH1 until mem_rdy. FETCH2: gateMDR, ldIR. DECODE: one idle cycle, then branch on IR[15:12].
- ADD/AND/NOT (1 cycle): gateALU, ldReg, flagWE. SR2 is IR[2:0]; immediate mode is handled in the datapath via IR[5].
- BR: if (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), then ldPC with selPC=01, selEAB1=0, selEAB2=10. Otherwise no loads. Opcode 0000 with nzp=000 is a NOP.
- JMP/RET: ldPC, selPC=01, selEAB1=1, selEAB2=00.
- JSR/JSRR: EX_JSR0 gatePC, ldReg, DR=7. EX_JSR1 ldPC via EAB (off11 if IR[11], else SR1+0).
- LD/LDR/ST/STR/LDI/STI: EX_EA loads MAR from EAB. LDI/STI then pass through EX_IND0 (memory read, wait mem_rdy) and EX_IND1 (gateMDR, ldMAR). Loads continue to EX_RD0 (read, wait) and EX_RD1 (gateMDR, ldReg, flagWE). Stores continue to EX_WR0 (SR1=IR[11:9], gateALU PASS, ldMDR selMDR=0) and EX_WR1 (mem_en+memWE until mem_rdy).
- LEA: gateMARMUX, ldReg, flagWE. LEA sets the flags, matching the datapath.
- TRAP: EX_TRAP0 selMAR=1, ldMAR, gatePC, ldReg DR=7. EX_TRAP1 reads memory (wait mem_rdy), then FETCH2-like gateMDR with ldPC selPC=10 and returns to FETCH0.
- RTI/reserved opcodes (1000, 1101): treated as NOP and return to FETCH0.
- Every execute path returns to FETCH0. mem_en stays high continuously while waiting.
- flagWE is asserted only in the same cycle as ldReg for ADD/AND/NOT/LD/LDR/LDI/LEA.

Optional Feature:
- LC3_HALT_EN defined: TRAP x25 enters HALT after writing R7. HALT holds all outputs at 0 until rst.
- Undefined: x25 executes as a normal TRAP.

Decomposition:
- Package lc3_pkg: opcode localparams, state enum, and selPC/selEAB2/aluControl encodings.
- Natural sub-module lc3_ctrl_decode: combinational per-state output decode, kept separate from the next-state register.

Test Plan:
- rst held 2 cycles, then released, with RESET_PC=16'h3000 -> ldPC=1 during reset; first FETCH0 cycle shows gatePC=1, ldMAR=1, ldPC=1.
- IR=16'h1261 (ADD R1,R1,#1), mem_rdy=1 immediately -> sequence FETCH0, FETCH1, FETCH2, DECODE, EX_ALU; EX_ALU has ldReg=1, flagWE=1, DR=1.
- IR=16'h0402 (BRz) with Z=1 -> ldPC=1, selPC=01. Same IR with Z=0, P=1 -> ldPC=0.
- LDI, mem_rdy delayed 3 cycles per access -> FSM waits each time; mem_en stays high; exactly 3 memory reads; flagWE pulses once.
- STR -> memWE=1 only in EX_WR1, held until mem_rdy; flagWE never asserted.
- TRAP x25: with LC3_HALT_EN, the FSM parks in HALT with all outputs 0. Without it, PC is loaded from the vector and the FSM returns to FETCH0.

Source files
------------

// File: rtl/lc3_pkg.sv
// ============================================================================
// Module      : lc3_pkg
// Description : Shared opcodes, FSM state encoding, datapath select encodings
//               and the control-word structure for the LC-3 control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3_pkg;

    // Opcodes, IR[15:12]
    localparam logic [3:0] c_OP_BR   = 4'b0000;
    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_LD   = 4'b0010;
    localparam logic [3:0] c_OP_ST   = 4'b0011;
    localparam logic [3:0] c_OP_JSR  = 4'b0100;
    localparam logic [3:0] c_OP_AND  = 4'b0101;
    localparam logic [3:0] c_OP_LDR  = 4'b0110;
    localparam logic [3:0] c_OP_STR  = 4'b0111;
    localparam logic [3:0] c_OP_RTI  = 4'b1000;
    localparam logic [3:0] c_OP_NOT  = 4'b1001;
    localparam logic [3:0] c_OP_LDI  = 4'b1010;
    localparam logic [3:0] c_OP_STI  = 4'b1011;
    localparam logic [3:0] c_OP_JMP  = 4'b1100;
    localparam logic [3:0] c_OP_RES  = 4'b1101;
    localparam logic [3:0] c_OP_LEA  = 4'b1110;
    localparam logic [3:0] c_OP_TRAP = 4'b1111;

    // PC input mux
    localparam logic [1:0] c_SELPC_INC = 2'b00;
    localparam logic [1:0] c_SELPC_EAB = 2'b01;
    localparam logic [1:0] c_SELPC_BUS = 2'b10;

    // Second EAB addend
    localparam logic [1:0] c_EAB2_ZERO  = 2'b00;
    localparam logic [1:0] c_EAB2_OFF6  = 2'b01;
    localparam logic [1:0] c_EAB2_OFF9  = 2'b10;
    localparam logic [1:0] c_EAB2_OFF11 = 2'b11;

    // ALU operation
    localparam logic [1:0] c_ALU_ADD  = 2'b00;
    localparam logic [1:0] c_ALU_AND  = 2'b01;
    localparam logic [1:0] c_ALU_NOT  = 2'b10;
    localparam logic [1:0] c_ALU_PASS = 2'b11;

    // Trap vector that parks the machine when halting is built in
    localparam logic [7:0] c_TRAP_HALT = 8'h25;

    // Link register used by JSR/JSRR/TRAP
    localparam logic [2:0] c_REG_LINK = 3'd7;

    typedef enum logic [4:0] {
        FETCH0   = 5'd0,
        FETCH1   = 5'd1,
        FETCH2   = 5'd2,
        DECODE   = 5'd3,
        EX_ALU   = 5'd4,
        EX_BR    = 5'd5,
        EX_JMP   = 5'd6,
        EX_JSR0  = 5'd7,
        EX_JSR1  = 5'd8,
        EX_EA    = 5'd9,
        EX_IND0  = 5'd10,
        EX_IND1  = 5'd11,
        EX_RD0   = 5'd12,
        EX_RD1   = 5'd13,
        EX_WR0   = 5'd14,
        EX_WR1   = 5'd15,
        EX_LEA   = 5'd16,
        EX_TRAP0 = 5'd17,
        EX_TRAP1 = 5'd18,
        EX_TRAP2 = 5'd19,
        HALT     = 5'd20
    } state_t;

    // Complete control word driven towards the datapath
    typedef struct packed {
        logic       ldPC;
        logic       ldIR;
        logic       ldMAR;
        logic       ldMDR;
        logic       ldReg;
        logic       flagWE;
        logic       gatePC;
        logic       gateMDR;
        logic       gateALU;
        logic       gateMARMUX;
        logic [1:0] selPC;
        logic       selEAB1;
        logic [1:0] selEAB2;
        logic       selMAR;
        logic       selMDR;
        logic [1:0] aluControl;
        logic [2:0] DR;
        logic [2:0] SR1;
        logic [2:0] SR2;
        logic       mem_en;
        logic       memWE;
    } ctrl_t;

    // Memory-operand opcodes that write a register (as opposed to stores)
    function automatic logic is_load(input logic [3:0] op);
        return (op == c_OP_LD) || (op == c_OP_LDR) || (op == c_OP_LDI);
    endfunction

    // Memory-operand opcodes that need the pointer fetch
    function automatic logic is_indirect(input logic [3:0] op);
        return (op == c_OP_LDI) || (op == c_OP_STI);
    endfunction

    // BR condition: any requested flag that is currently set
    function automatic logic br_taken(input logic [15:0] ir,
                                      input logic n, input logic z, input logic p);
        return (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lc3_ctrl_decode.sv
// ============================================================================
// Module      : lc3_ctrl_decode
// Description : Combinational per-state control-word decode for the LC-3
//               sequencer. Memory-completion qualifiers (ldMDR on a read)
//               follow mem_rdy within the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_ctrl_decode
    import lc3_pkg::*;
(
    input  logic        rst,
    input  state_t      state,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    input  logic        mem_rdy,
    output ctrl_t       ctl
);

    logic [3:0] w_op;
    logic       w_unused_ir;

    assign w_op        = ir[15:12];
    assign w_unused_ir = ^ir[5:3];

    // Translate the current state (or reset) into the datapath control word
    always_comb begin
        ctl = '0;
        if (rst) begin
            ctl.ldPC  = 1'b1;
            ctl.selPC = c_SELPC_BUS;
        end else begin
            case (state)
                FETCH0: begin
                    ctl.gatePC = 1'b1;
                    ctl.ldMAR  = 1'b1;
                    ctl.ldPC   = 1'b1;
                    ctl.selPC  = c_SELPC_INC;
                end
                FETCH1, EX_IND0, EX_RD0, EX_TRAP1: begin
                    ctl.mem_en = 1'b1;
                    ctl.selMDR = 1'b1;
                    ctl.ldMDR  = mem_rdy;
                end
                FETCH2: begin
                    ctl.gateMDR = 1'b1;
                    ctl.ldIR    = 1'b1;
                end
                EX_ALU: begin
                    ctl.gateALU = 1'b1;
                    ctl.ldReg   = 1'b1;
                    ctl.flagWE  = 1'b1;
                    ctl.DR      = ir[11:9];
                    ctl.SR1     = ir[8:6];
                    ctl.SR2     = ir[2:0];
                    case (w_op)
                        c_OP_AND: ctl.aluControl = c_ALU_AND;
                        c_OP_NOT: ctl.aluControl = c_ALU_NOT;
                        default:  ctl.aluControl = c_ALU_ADD;
                    endcase
                end
                EX_BR: begin
                    ctl.selPC   = c_SELPC_EAB;
                    ctl.selEAB1 = 1'b0;
                    ctl.selEAB2 = c_EAB2_OFF9;
                    ctl.ldPC    = br_taken(ir, n, z, p);
                end
                EX_JMP: begin
                    ctl.ldPC    = 1'b1;
                    ctl.selPC   = c_SELPC_EAB;
                    ctl.selEAB1 = 1'b1;
                    ctl.selEAB2 = c_EAB2_ZERO;
                    ctl.SR1     = ir[8:6];
                end
                EX_JSR0: begin
                    ctl.gatePC = 1'b1;
                    ctl.ldReg  = 1'b1;
                    ctl.DR     = c_REG_LINK;
                end
                EX_JSR1: begin
                    ctl.ldPC  = 1'b1;
                    ctl.selPC = c_SELPC_EAB;
                    if (ir[11]) begin
                        ctl.selEAB1 = 1'b0;
                        ctl.selEAB2 = c_EAB2_OFF11;
                    end else begin
                        ctl.selEAB1 = 1'b1;
                        ctl.selEAB2 = c_EAB2_ZERO;
                        ctl.SR1     = ir[8:6];
                    end
                end
                EX_EA: begin
                    ctl.gateMARMUX = 1'b1;
                    ctl.selMAR     = 1'b0;
                    ctl.ldMAR      = 1'b1;
                    if ((w_op == c_OP_LDR) || (w_op == c_OP_STR)) begin
                        ctl.selEAB1 = 1'b1;
                        ctl.selEAB2 = c_EAB2_OFF6;
                        ctl.SR1     = ir[8:6];
                    end else begin
                        ctl.selEAB1 = 1'b0;
                        ctl.selEAB2 = c_EAB2_OFF9;
                    end
                end
                EX_IND1: begin
                    ctl.gateMDR = 1'b1;
                    ctl.ldMAR   = 1'b1;
                end
                EX_RD1: begin
                    ctl.gateMDR = 1'b1;
                    ctl.ldReg   = 1'b1;
                    ctl.flagWE  = 1'b1;
                    ctl.DR      = ir[11:9];
                end
                EX_WR0: begin
                    ctl.SR1        = ir[11:9];
                    ctl.gateALU    = 1'b1;
                    ctl.aluControl = c_ALU_PASS;
                    ctl.ldMDR      = 1'b1;
                    ctl.selMDR     = 1'b0;
                end
                EX_WR1: begin
                    ctl.mem_en = 1'b1;
                    ctl.memWE  = 1'b1;
                end
                EX_LEA: begin
                    ctl.gateMARMUX = 1'b1;
                    ctl.selMAR     = 1'b0;
                    ctl.selEAB1    = 1'b0;
                    ctl.selEAB2    = c_EAB2_OFF9;
                    ctl.ldReg      = 1'b1;
                    ctl.flagWE     = 1'b1;
                    ctl.DR         = ir[11:9];
                end
                EX_TRAP0: begin
                    ctl.selMAR = 1'b1;
                    ctl.ldMAR  = 1'b1;
                    ctl.gatePC = 1'b1;
                    ctl.ldReg  = 1'b1;
                    ctl.DR     = c_REG_LINK;
                end
                EX_TRAP2: begin
                    ctl.gateMDR = 1'b1;
                    ctl.ldPC    = 1'b1;
                    ctl.selPC   = c_SELPC_BUS;
                end
                default: ;  // DECODE, HALT: everything idle
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/lc3_ctrl_fsm.sv
// ============================================================================
// Module      : lc3_ctrl_fsm
// Description : Multi-cycle fetch/decode/execute sequencer for the LC-3
//               datapath, with variable-latency memory handshake.
//               Build option LC3_HALT_EN: TRAP x25 parks the machine in HALT
//               (all controls low) after R7 is written, until reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_ctrl_fsm
    import lc3_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    input  logic        mem_rdy,
    output logic        ldPC,
    output logic        ldIR,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        ldReg,
    output logic        flagWE,
    output logic        gatePC,
    output logic        gateMDR,
    output logic        gateALU,
    output logic        gateMARMUX,
    output logic [1:0]  selPC,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic        selMAR,
    output logic        selMDR,
    output logic [1:0]  aluControl,
    output logic [2:0]  DR,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic        mem_en,
    output logic        memWE,
    output logic [15:0] pc_init
);

    state_t     r_state;
    ctrl_t      w_ctl;
    logic [3:0] w_op;

    assign w_op = IR[15:12];

    // Sequence through fetch, decode and the per-opcode execute paths
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH0;
        end else begin
            case (r_state)
                FETCH0:   r_state <= FETCH1;
                FETCH1:   if (mem_rdy) r_state <= FETCH2;
                FETCH2:   r_state <= DECODE;
                DECODE: begin
                    case (w_op)
                        c_OP_ADD, c_OP_AND, c_OP_NOT: r_state <= EX_ALU;
                        c_OP_BR:                      r_state <= EX_BR;
                        c_OP_JMP:                     r_state <= EX_JMP;
                        c_OP_JSR:                     r_state <= EX_JSR0;
                        c_OP_LD, c_OP_LDR, c_OP_LDI,
                        c_OP_ST, c_OP_STR, c_OP_STI:  r_state <= EX_EA;
                        c_OP_LEA:                     r_state <= EX_LEA;
                        c_OP_TRAP:                    r_state <= EX_TRAP0;
                        default:                      r_state <= FETCH0;
                    endcase
                end
                EX_JSR0:  r_state <= EX_JSR1;
                EX_EA: begin
                    if (is_indirect(w_op))  r_state <= EX_IND0;
                    else if (is_load(w_op)) r_state <= EX_RD0;
                    else                    r_state <= EX_WR0;
                end
                EX_IND0:  if (mem_rdy) r_state <= EX_IND1;
                EX_IND1:  r_state <= is_load(w_op) ? EX_RD0 : EX_WR0;
                EX_RD0:   if (mem_rdy) r_state <= EX_RD1;
                EX_WR0:   r_state <= EX_WR1;
                EX_WR1:   if (mem_rdy) r_state <= FETCH0;
`ifdef LC3_HALT_EN
                EX_TRAP0: r_state <= (IR[7:0] == c_TRAP_HALT) ? HALT : EX_TRAP1;
                HALT:     r_state <= HALT;
`else
                EX_TRAP0: r_state <= EX_TRAP1;
`endif
                EX_TRAP1: if (mem_rdy) r_state <= EX_TRAP2;
                default:  r_state <= FETCH0;  // single-cycle executes and TRAP2
            endcase
        end
    end

    lc3_ctrl_decode u_decode (
        .rst     (rst),
        .state   (r_state),
        .ir      (IR),
        .n       (N),
        .z       (Z),
        .p       (P),
        .mem_rdy (mem_rdy),
        .ctl     (w_ctl)
    );

    assign ldPC       = w_ctl.ldPC;
    assign ldIR       = w_ctl.ldIR;
    assign ldMAR      = w_ctl.ldMAR;
    assign ldMDR      = w_ctl.ldMDR;
    assign ldReg      = w_ctl.ldReg;
    assign flagWE     = w_ctl.flagWE;
    assign gatePC     = w_ctl.gatePC;
    assign gateMDR    = w_ctl.gateMDR;
    assign gateALU    = w_ctl.gateALU;
    assign gateMARMUX = w_ctl.gateMARMUX;
    assign selPC      = w_ctl.selPC;
    assign selEAB1    = w_ctl.selEAB1;
    assign selEAB2    = w_ctl.selEAB2;
    assign selMAR     = w_ctl.selMAR;
    assign selMDR     = w_ctl.selMDR;
    assign aluControl = w_ctl.aluControl;
    assign DR         = w_ctl.DR;
    assign SR1        = w_ctl.SR1;
    assign SR2        = w_ctl.SR2;
    assign mem_en     = w_ctl.mem_en;
    assign memWE      = w_ctl.memWE;
    assign pc_init    = RESET_PC;

endmodule

`default_nettype wire

// File: tb/tb_lc3_ctrl_fsm.sv
// ============================================================================
// Module      : tb_lc3_ctrl_fsm
// Description : Directed self-checking bench for lc3_ctrl_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] IR;
    logic        N, Z, P, mem_rdy;
    logic        ldPC, ldIR, ldMAR, ldMDR, ldReg, flagWE;
    logic        gatePC, gateMDR, gateALU, gateMARMUX;
    logic [1:0]  selPC, selEAB2, aluControl;
    logic        selEAB1, selMAR, selMDR;
    logic [2:0]  DR, SR1, SR2;
    logic        mem_en, memWE;
    logic [15:0] pc_init;

    int checks = 0;
    int errors = 0;
    int n_rd   = 0;  // completed memory reads
    int n_flag = 0;  // flagWE cycles
    int n_we   = 0;  // cycles with memWE high
    int n_wr   = 0;  // completed memory writes
    int rd0, fl0, we0, wr0;

    // {ldPC,ldIR,ldMAR,ldMDR,ldReg,flagWE,gatePC,gateMDR,gateALU,gateMARMUX,mem_en,memWE}
    logic [11:0] ctl;
    assign ctl = {ldPC, ldIR, ldMAR, ldMDR, ldReg, flagWE,
                  gatePC, gateMDR, gateALU, gateMARMUX, mem_en, memWE};

    lc3_ctrl_fsm #(.RESET_PC(16'h3000)) dut (
        .clk(clk), .rst(rst), .IR(IR), .N(N), .Z(Z), .P(P), .mem_rdy(mem_rdy),
        .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR), .ldReg(ldReg),
        .flagWE(flagWE), .gatePC(gatePC), .gateMDR(gateMDR), .gateALU(gateALU),
        .gateMARMUX(gateMARMUX), .selPC(selPC), .selEAB1(selEAB1),
        .selEAB2(selEAB2), .selMAR(selMAR), .selMDR(selMDR),
        .aluControl(aluControl), .DR(DR), .SR1(SR1), .SR2(SR2),
        .mem_en(mem_en), .memWE(memWE), .pc_init(pc_init)
    );

    always #5 clk = ~clk;

    // Count memory and flag activity as it is committed at each edge
    always @(posedge clk) begin
        if (!rst) begin
            if (mem_en && mem_rdy && !memWE) n_rd = n_rd + 1;
            if (mem_en && mem_rdy && memWE)  n_wr = n_wr + 1;
            if (flagWE)                      n_flag = n_flag + 1;
            if (memWE)                       n_we = n_we + 1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then drive mem_rdy for the new cycle
    task automatic step(input logic rdy);
        @(posedge clk);
        #1;
        mem_rdy = rdy;
        #1;
    endtask

    // Current state just entered: hold mem_rdy low for dly cycles, then high
    task automatic wait_mem(input string tag, input int dly,
                            input logic [11:0] exp_wait, input logic [11:0] exp_done);
        for (int i = 0; i <= dly; i++) begin
            if (i > 0) step(i == dly);
            else begin
                mem_rdy = (dly == 0);
                #1;
            end
            chk(tag, {4'h0, ctl}, {4'h0, (i == dly) ? exp_done : exp_wait});
        end
    endtask

    // From a settled FETCH0 cycle, run the fetch and land in the first execute state
    task automatic do_fetch(input string tag, input logic [15:0] ir, input int dly);
        IR = ir;
        #1;
        chk({tag, "_f0"}, {4'h0, ctl}, 16'h0A20);
        step(1'b0);
        wait_mem({tag, "_f1"}, dly, 12'h002, 12'h102);
        step(1'b0);
        chk({tag, "_f2"}, {4'h0, ctl}, 16'h0410);
        step(1'b0);
        chk({tag, "_dec"}, {4'h0, ctl}, 16'h0000);
        step(1'b0);
    endtask

    initial begin
        rst = 1'b1; IR = 16'h0000; N = 1'b0; Z = 1'b0; P = 1'b0; mem_rdy = 1'b1;

        // Reset held two cycles; mem_rdy high must be ignored
        @(posedge clk); #1;
        chk("rst_ctl0", {4'h0, ctl}, 16'h0800);
        chk("rst_selpc", {14'h0, selPC}, 16'h0002);
        chk("pc_init", pc_init, 16'h3000);
        @(posedge clk); #1;
        chk("rst_ctl1", {4'h0, ctl}, 16'h0800);
        chk("rst_dr", {13'h0, DR}, 16'h0000);
        rst = 1'b0; mem_rdy = 1'b0;
        #1;
        chk("first_f0", {4'h0, ctl}, 16'h0A20);
        chk("first_f0_selpc", {14'h0, selPC}, 16'h0000);

        // ADD R1,R1,#1
        do_fetch("add", 16'h1261, 0);
        chk("add_ex", {4'h0, ctl}, 16'h00C8);
        chk("add_dr", {13'h0, DR}, 16'h0001);
        chk("add_sr1", {13'h0, SR1}, 16'h0001);
        chk("add_alu", {14'h0, aluControl}, 16'h0000);
        step(1'b0);

        // BRz taken
        Z = 1'b1;
        do_fetch("brz_t", 16'h0402, 0);
        chk("brz_t_ex", {4'h0, ctl}, 16'h0800);
        chk("brz_t_selpc", {14'h0, selPC}, 16'h0001);
        chk("brz_t_eab2", {14'h0, selEAB2}, 16'h0002);
        step(1'b0);

        // BRz not taken with only P set
        Z = 1'b0; P = 1'b1;
        do_fetch("brz_n", 16'h0402, 0);
        chk("brz_n_ex", {4'h0, ctl}, 16'h0000);
        step(1'b0);

        // JSR with an 11-bit offset
        do_fetch("jsr", 16'h4803, 0);
        chk("jsr0", {4'h0, ctl}, 16'h00A0);
        chk("jsr0_dr", {13'h0, DR}, 16'h0007);
        step(1'b0);
        chk("jsr1", {4'h0, ctl}, 16'h0800);
        chk("jsr1_sel", {11'h0, selPC, selEAB1, selEAB2}, {11'h0, 2'b01, 1'b0, 2'b11});
        step(1'b0);

        // LDI R2 with three-cycle latency on every access
        rd0 = n_rd; fl0 = n_flag;
        do_fetch("ldi", 16'hA405, 3);
        chk("ldi_ea", {4'h0, ctl}, 16'h0204);
        step(1'b0);
        wait_mem("ldi_ind0", 3, 12'h002, 12'h102);
        step(1'b0);
        chk("ldi_ind1", {4'h0, ctl}, 16'h0210);
        step(1'b0);
        wait_mem("ldi_rd0", 3, 12'h002, 12'h102);
        step(1'b0);
        chk("ldi_rd1", {4'h0, ctl}, 16'h00D0);
        chk("ldi_dr", {13'h0, DR}, 16'h0002);
        step(1'b0);
        chk("ldi_back_f0", {4'h0, ctl}, 16'h0A20);
        chk("ldi_reads", 16'(n_rd - rd0), 16'd3);
        chk("ldi_flags", 16'(n_flag - fl0), 16'd1);

        // STR R3,R4,#1 with two-cycle write latency
        fl0 = n_flag; we0 = n_we; wr0 = n_wr;
        do_fetch("str", 16'h7701, 0);
        chk("str_ea", {4'h0, ctl}, 16'h0204);
        chk("str_ea_sel", {10'h0, selEAB1, selEAB2, SR1}, {10'h0, 1'b1, 2'b01, 3'd4});
        step(1'b0);
        chk("str_wr0", {4'h0, ctl}, 16'h0108);
        chk("str_wr0_sel", {10'h0, aluControl, selMDR, SR1}, {10'h0, 2'b11, 1'b0, 3'd3});
        step(1'b0);
        wait_mem("str_wr1", 2, 12'h003, 12'h003);
        step(1'b0);
        chk("str_back_f0", {4'h0, ctl}, 16'h0A20);
        chk("str_flags", 16'(n_flag - fl0), 16'd0);
        chk("str_we_cycles", 16'(n_we - we0), 16'd3);
        chk("str_writes", 16'(n_wr - wr0), 16'd1);

        // RTI acts as a NOP: DECODE goes straight back to FETCH0
        do_fetch("rti", 16'h8000, 0);
        chk("rti_f0", {4'h0, ctl}, 16'h0A20);

        // Reset during a pending fetch read abandons it
        step(1'b0);
        chk("mid_f1", {4'h0, ctl}, 16'h0002);
        rst = 1'b1; mem_rdy = 1'b1;
        #1;
        chk("mid_rst", {4'h0, ctl}, 16'h0800);
        @(posedge clk); #1;
        rst = 1'b0; mem_rdy = 1'b0;
        #1;
        chk("mid_f0", {4'h0, ctl}, 16'h0A20);

        // TRAP x25
        do_fetch("trap", 16'hF025, 0);
        chk("trap0", {4'h0, ctl}, 16'h02A0);
        chk("trap0_sel", {12'h0, selMAR, DR}, {12'h0, 1'b1, 3'd7});
`ifdef LC3_HALT_EN
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            chk("halt_ctl", {4'h0, ctl}, 16'h0000);
            chk("halt_sel", {9'h0, selPC, DR, selEAB2}, 16'h0000);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("halt_rst", {4'h0, ctl}, 16'h0800);
        rst = 1'b0; mem_rdy = 1'b0;
        #1;
        chk("halt_exit_f0", {4'h0, ctl}, 16'h0A20);
`else
        step(1'b0);
        wait_mem("trap1", 1, 12'h002, 12'h102);
        step(1'b0);
        chk("trap2", {4'h0, ctl}, 16'h0810);
        chk("trap2_selpc", {14'h0, selPC}, 16'h0002);
        step(1'b0);
        chk("trap_back_f0", {4'h0, ctl}, 16'h0A20);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
